uart_rx_oversampled: RTL and testbench
======================================

// Module: uart_rx_oversampled
// PURPOSE
//  UART receiver driven by the 16x oversampling tick from the baud rate generator (one-clock strobe).
//  - Frame: 8N1, LSB first.
//  - Serial line is synchronised, then sampled at mid-bit.
//  - Each received byte is held in a buffer until the consumer acknowledges it.
//  - Sits between the board RX pin and the command/datapath logic.
// PARAMETERS
//  DBIT      8   data bits per frame
//  SB_TICK   16  ticks spent in the stop bit (16 = 1 stop bit, 32 = 2)
//  OVS       16  oversampling ratio; mid-bit = OVS/2-1
// PORTS
//  clock      in   1     system clock, rising edge
//  reset_n    in   1     asynchronous, active-low reset
//  tick       in   1     oversampling strobe, 1 clock wide, OVS per bit period
//  rx         in   1     serial line, idle high, asynchronous to clock
//  rd         in   1     consumer acknowledge; clears data_valid
//  dout       out  DBIT  last received byte (held)
//  data_valid out  1     dout holds an unread byte
//  rx_done    out  1     one-clock pulse when a frame completes
//  frame_err  out  1     stop bit of the last frame sampled low
//  overrun    out  1     sticky: a byte completed while data_valid=1
// BEHAVIOUR
//  - Reset (async, reset_n=0):
//    - state=IDLE; all counters=0; shift register=0.
//    - dout=0, data_valid=0, rx_done=0, frame_err=0, overrun=0.
//    - Synchroniser flops reset to 1 (idle line).
//  - rx passes through a 2-flop synchroniser; rx_s is the synchronised value. Add 2 clocks of latency.
//  - FSM states: IDLE, START, DATA, STOP.
//    - s = tick counter, 0..max(OVS,SB_TICK)-1; n = bit counter, 0..DBIT-1.
//  - IDLE: rx_s==0 -> START, s=0. Ticks are ignored while in IDLE.
//  - START: on tick with s==OVS/2-1:
//    - rx_s==0 -> DATA, s=0, n=0.
//    - rx_s==1 -> IDLE, glitch rejected, no flags.
//    - Otherwise, on tick: s=s+1.
//  - DATA: on tick with s==OVS-1:
//    - Shift right: shreg={rx_s, shreg[DBIT-1:1]}; s=0.
//    - n==DBIT-1 -> STOP; else n=n+1.
//  - STOP: on tick with s==SB_TICK-1, go to IDLE and in that same clock:
//    - rx_done=1 for one clock.
//    - dout=shreg.
//    - frame_err=~rx_s (updated every frame, not sticky).
//    - data_valid=1.
//    - overrun set if data_valid was 1 and rd=0 in that clock.
//  - A byte with frame_err=1 is still delivered to dout and data_valid.
//  - rd: data_valid=0 next clock. rd while data_valid=0 has no effect.
//  - rd in the same clock as frame completion: completion wins; data_valid stays 1, no overrun.
//  - overrun is cleared only by reset.
//  - Timing: the sample point sits OVS/2 ticks after the detected falling edge, then every OVS ticks.
//    - rx_done asserts in the clock of the final stop tick.
//  - Line held low (break): frame_err=1 on completion. FSM returns to IDLE and immediately re-enters START.
//  - reset_n asserted mid-frame: partial byte discarded, no rx_done. Receiver re-arms on the next falling edge.
//  - Counter widths: s is $clog2(max(OVS,SB_TICK)) bits, n is $clog2(DBIT) bits. Compares wrap-free.
// STRUCTURE
//  - Shared package (uart_pkg):
//    - State encoding localparams: IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11.
//    - UART_DBIT, UART_OVS and SB_TICK defaults shared with the transmitter.
//  - Sub-module sync_2ff (2-flop synchroniser, reset value parameterised). Reused for other async pins.
//  - FSM and datapath stay in this module.
// TESTING
//  Bench: tick from the 164-clock divider (period 164 clocks) or an accelerated 4-clock tick.
//  1. Send 0x55, stop=1 -> rx_done pulses once; dout=8'h55; data_valid=1; frame_err=0.
//  2. Send 0xA3, then pulse rd -> data_valid falls next clock; dout stays 8'hA3.
//  3. Low glitch of 3 ticks on idle line -> returns to IDLE; no rx_done; flags unchanged.
//  4. Send 0x0F with stop bit=0 -> dout=8'h0F; frame_err=1. Next good 0x10 -> frame_err=0.
//  5. Send 0x11 then 0x22 without rd -> overrun=1; dout=8'h22.
//     Repeat with rd in the completion clock -> overrun stays 0.
//  6. Assert reset_n=0 during bit 4 of 0x7E -> all outputs 0.
//     After release, 0xC4 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults common to receiver and transmitter,
// receiver state encoding and a small sizing helper.
package uart_pkg;

  localparam int UART_DBIT    = 8;
  localparam int UART_OVS     = 16;
  localparam int UART_SB_TICK = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Consumer-side bundle of the UART receiver: received byte, status flags and
// the read acknowledge. The receiver is the master, the consumer the slave.
interface uart_rx_oversampled_if
  import uart_pkg::*;
#(
  parameter int DBIT = UART_DBIT
);

  logic            rd;
  logic [DBIT-1:0] dout;
  logic            data_valid;
  logic            rx_done;
  logic            frame_err;
  logic            overrun;

  modport master (
    input  rd,
    output dout, data_valid, rx_done, frame_err, overrun
  );

  modport slave (
    output rd,
    input  dout, data_valid, rx_done, frame_err, overrun
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; the reset value is a
// parameter so idle-high and idle-low pins can share it.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments make the two stages shift together; blocking would collapse them into one flop.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver on a 16x oversampling strobe: start-bit glitch rejection,
// mid-bit sampling and a one-deep output buffer with frame-error and overrun flags.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int DBIT    = UART_DBIT,
  parameter int SB_TICK = UART_SB_TICK,
  parameter int OVS     = UART_OVS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic                  rx,
  uart_rx_oversampled_if.master bus
);

  localparam int S_W = $clog2(max_int(OVS, SB_TICK));
  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [S_W-1:0] S_MID  = S_W'(OVS / 2 - 1);
  localparam logic [S_W-1:0] S_BIT  = S_W'(OVS - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

  rx_state_t       state, state_next;
  logic [S_W-1:0]  s, s_next;
  logic [N_W-1:0]  n, n_next;
  logic [DBIT-1:0] shreg, shreg_next;
  logic            rx_s;
  logic            done;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      shreg <= '0;
    end else begin
      state <= state_next;
      s     <= s_next;
      n     <= n_next;
      shreg <= shreg_next;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves one unassigned and infers a latch.
    state_next = state;
    s_next     = s;
    n_next     = n;
    shreg_next = shreg;
    done       = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s == S_MID) begin
            // A start bit that is high again at its centre was only a glitch.
            if (!rx_s) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s + S_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == S_BIT) begin
            shreg_next = {rx_s, shreg[DBIT-1:1]};
            s_next     = '0;
            if (n == N_LAST) state_next = STOP;
            else             n_next     = n + N_W'(1);
          end else begin
            s_next = s + S_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s == S_STOP) begin
            state_next = IDLE;
            done       = 1'b1;
          end else begin
            s_next = s + S_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output buffer: a completing frame takes priority over a same-clock acknowledge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.dout       <= '0;
      bus.data_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      if (done) begin
        bus.dout       <= shreg;
        bus.frame_err  <= ~rx_s;
        bus.data_valid <= 1'b1;
        if (bus.data_valid && !bus.rd) bus.overrun <= 1'b1;
      end else if (bus.rd) begin
        bus.data_valid <= 1'b0;
      end
    end
  end

  assign bus.rx_done = done;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled on an accelerated tick (1 clock in 4),
// so one bit period is 64 clocks.
module tb_uart_rx_oversampled;
  import uart_pkg::*;

  localparam int BIT_CLKS = 64;

  typedef struct {
    logic [7:0] dout;
    logic       fe;
    logic       ov;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic tick    = 1'b0;
  logic rx      = 1'b1;
  logic rd_main = 1'b0;
  logic rd_ack  = 1'b0;
  logic ack_on_done = 1'b0;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic       m_dv, m_ov, m_fe;
  logic [7:0] m_dout;

  uart_rx_oversampled_if #(.DBIT(8)) bus ();

  assign bus.rd = rd_main | rd_ack;

  uart_rx_oversampled #(.DBIT(8), .SB_TICK(16), .OVS(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (tick),
    .rx      (rx),
    .bus     (bus.master)
  );

  always #5 clock = ~clock;

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clock);
      tick = (c == 3);
      c = (c + 1) % 4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    check("dout", 32'(bus.dout), 32'(m_dout));
    check("data_valid", 32'(bus.data_valid), 32'(m_dv));
    check("frame_err", 32'(bus.frame_err), 32'(m_fe));
    check("overrun", 32'(bus.overrun), 32'(m_ov));
  endtask

  // Acknowledge exactly in the completion clock when asked to.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      rd_ack = ack_on_done & bus.rx_done;
    end
  end

  // Monitor: every rx_done pops one expectation; outputs are checked after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (bus.rx_done) begin
        if (sb_q.size() == 0) begin
          check("spurious_rx_done", 32'(bus.rx_done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          @(posedge clock);
          #1;
          check("sb_dout", 32'(bus.dout), 32'(e.dout));
          check("sb_data_valid", 32'(bus.data_valid), 32'd1);
          check("sb_frame_err", 32'(bus.frame_err), 32'(e.fe));
          check("sb_overrun", 32'(bus.overrun), 32'(e.ov));
          check("rx_done_width", 32'(bus.rx_done), 32'd0);
        end
      end
    end
  end

  // Called at a falling edge; a low stop bit is held only past its sample point.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic ack);
    exp_t e;
    ack_on_done = ack;
    m_ov   = m_ov | (m_dv & ~ack);
    m_dv   = 1'b1;
    m_dout = data;
    m_fe   = ~stop;
    e.dout = data;
    e.fe   = ~stop;
    e.ov   = m_ov;
    sb_q.push_back(e);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (BIT_CLKS) @(negedge clock);
    end
    rx = stop;
    repeat (stop ? BIT_CLKS : 48) @(negedge clock);
    rx = 1'b1;
    repeat (96) @(negedge clock);
    ack_on_done = 1'b0;
  endtask

  task automatic rd_pulse();
    rd_main = 1'b1;
    @(posedge clock);
    #1;
    m_dv = 1'b0;
    check_outputs();
    @(negedge clock);
    rd_main = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b7e;
    m_dv = 1'b0; m_ov = 1'b0; m_fe = 1'b0; m_dout = 8'h00;

    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_rx_done", 32'(bus.rx_done), 32'd0);
    check_outputs();
    reset_n = 1'b1;
    repeat (10) @(negedge clock);

    // Basic frame, then acknowledge it.
    send_frame(8'h55, 1'b1, 1'b0);
    check_outputs();
    rd_pulse();

    // Acknowledge clears data_valid but dout holds; a second rd is harmless.
    send_frame(8'hA3, 1'b1, 1'b0);
    check("a3_valid_before_rd", 32'(bus.data_valid), 32'd1);
    rd_pulse();
    rd_pulse();

    // Short low glitch on an idle line: no frame, flags unchanged.
    rx = 1'b0;
    repeat (12) @(negedge clock);
    rx = 1'b1;
    repeat (128) @(negedge clock);
    check_outputs();

    // Stop bit low is still delivered, flagged; the next good frame clears it.
    send_frame(8'h0F, 1'b0, 1'b0);
    check_outputs();
    rd_pulse();
    send_frame(8'h10, 1'b1, 1'b0);
    check_outputs();

    // rd in the completion clock wins nothing: no overrun. Then an unread byte overruns.
    send_frame(8'h11, 1'b1, 1'b1);
    check_outputs();
    send_frame(8'h22, 1'b1, 1'b0);
    check_outputs();

    // Reset in the middle of bit 4 of 0x7E.
    b7e = 8'h7E;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      rx = b7e[i];
      repeat (BIT_CLKS) @(negedge clock);
    end
    rx = b7e[4];
    repeat (BIT_CLKS / 2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    m_dv = 1'b0; m_ov = 1'b0; m_fe = 1'b0; m_dout = 8'h00;
    check("midframe_reset_rx_done", 32'(bus.rx_done), 32'd0);
    check_outputs();
    repeat (5) @(negedge clock);
    rx = 1'b1;
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    send_frame(8'hC4, 1'b1, 1'b0);
    check_outputs();

    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clock);
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
